// File: rtl/baud_sched.sv
// baud_sched: round-robin arbiter that shares one clk_gen baud generator
// among NREQ UART engines. The winner's baud code is programmed into the
// generator (skipped when it already matches the live setting), then the
// winner holds an exclusive grant and receives a tick per tx_clk rising edge.
// Optional feature macro: BAUD_SCHED_TIMEOUT_EN (forced release after
// MAX_EDGES ticks). Default build: grant held while requested.
//
// state   | meaning
// IDLE    | no owner; arbitrate when any req is high
// CFG     | gen_baud applied, gen_rst held high for CFG_CYCLES
// SETTLE  | generator released, wait SETTLE_CYCLES before granting
// ACTIVE  | grant[owner] high, tick per gen_clk rising edge
// RELEASE | one dead cycle with no grant, then back to IDLE
module baud_sched #(
  parameter int NREQ          = 4,
  parameter int CFG_CYCLES    = 2,
  parameter int SETTLE_CYCLES = 2,
  parameter int MAX_EDGES     = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [3*NREQ-1:0]   baud_code,
  input  logic                gen_clk,
  output logic [16:0]         gen_baud,
  output logic                gen_rst,
  output logic [NREQ-1:0]     grant,
  output logic                tick,
  output logic                busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = 16;

  typedef enum logic [2:0] {IDLE, CFG, SETTLE, ACTIVE, RELEASE} state_t;

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   owner;
  logic [2:0]      code;
  logic [2:0]      cur_code;
  logic            cfg_valid;
  logic            gen_clk_q;
  logic [CW-1:0]   phase_cnt;
  logic [PW-1:0]   idx;
  logic [PW-1:0]   win_idx;
  logic [PW-1:0]   next_ptr;
  logic            win_found;
  logic            gen_rise;
  logic            timeout;
  logic [2:0]      codes [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_codes
    assign codes[i] = baud_code[3*i +: 3];
  end

  assign gen_rise = gen_clk & ~gen_clk_q;
  assign next_ptr = (win_idx == PW'(NREQ-1)) ? '0 : win_idx + PW'(1);

  function automatic logic [16:0] baud_of(input logic [2:0] c);
    case (c)
      3'd0:    baud_of = 17'd4800;
      3'd1:    baud_of = 17'd9600;
      3'd2:    baud_of = 17'd14400;
      3'd3:    baud_of = 17'd19200;
      3'd4:    baud_of = 17'd38400;
      3'd5:    baud_of = 17'd57600;
      default: baud_of = 17'd9600;
    endcase
  endfunction

  // Round-robin search: first requester at or after rr_ptr wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx       = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      idx = PW'((int'(rr_ptr) + k) % NREQ);
      if (req[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

`ifdef BAUD_SCHED_TIMEOUT_EN
  localparam int EW = (MAX_EDGES > 2) ? $clog2(MAX_EDGES) : 1;
  logic [EW-1:0] edge_cnt;

  // Tick budget for the current owner; reloaded whenever not in ACTIVE.
  always_ff @(posedge clk) begin
    if (!rst)
      edge_cnt <= '0;
    else if (state != ACTIVE)
      edge_cnt <= EW'(MAX_EDGES-1);
    else if (tick && edge_cnt != '0)
      edge_cnt <= edge_cnt - EW'(1);
  end

  assign timeout = tick && (edge_cnt == '0);
`else
  // Edge budget disabled: an owner is never forced out.
  assign timeout = (MAX_EDGES < 1);
`endif

  // Scheduler FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      grant     <= '0;
      tick      <= 1'b0;
      busy      <= 1'b0;
      gen_rst   <= 1'b1;
      gen_baud  <= 17'd9600;
      rr_ptr    <= '0;
      owner     <= '0;
      code      <= 3'd1;
      cfg_valid <= 1'b0;
      cur_code  <= 3'd1;
      gen_clk_q <= 1'b0;
      phase_cnt <= '0;
    end else begin
      gen_clk_q <= gen_clk;
      case (state)
        IDLE: begin
          grant   <= '0;
          tick    <= 1'b0;
          gen_rst <= ~cfg_valid;
          if (win_found) begin
            owner  <= win_idx;
            code   <= codes[win_idx];
            rr_ptr <= next_ptr;
            busy   <= 1'b1;
            if (cfg_valid && codes[win_idx] == cur_code) begin
              state   <= ACTIVE;
              grant   <= NREQ'(1) << win_idx;
              gen_rst <= 1'b0;
            end else begin
              state     <= CFG;
              gen_baud  <= baud_of(codes[win_idx]);
              gen_rst   <= 1'b1;
              cfg_valid <= 1'b0;
              phase_cnt <= CW'(CFG_CYCLES-1);
            end
          end
        end
        CFG: begin
          if (!req[owner]) begin
            state <= RELEASE;
          end else if (phase_cnt == '0) begin
            state     <= SETTLE;
            gen_rst   <= 1'b0;
            phase_cnt <= CW'(SETTLE_CYCLES-1);
          end else begin
            phase_cnt <= phase_cnt - CW'(1);
          end
        end
        SETTLE: begin
          if (!req[owner]) begin
            state <= RELEASE;
          end else if (phase_cnt == '0) begin
            state     <= ACTIVE;
            grant     <= NREQ'(1) << owner;
            cfg_valid <= 1'b1;
            cur_code  <= code;
          end else begin
            phase_cnt <= phase_cnt - CW'(1);
          end
        end
        ACTIVE: begin
          if (!req[owner] || timeout) begin
            state <= RELEASE;
            grant <= '0;
            tick  <= 1'b0;
          end else begin
            tick <= gen_rise;
          end
        end
        RELEASE: begin
          state   <= IDLE;
          grant   <= '0;
          tick    <= 1'b0;
          busy    <= 1'b0;
          gen_rst <= ~cfg_valid;
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          tick  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_baud_sched.sv
// Self-checking bench for baud_sched: directed scenarios plus randomized
// arbitration rounds checked against a transaction-level reference model.
// Define BAUD_SCHED_TIMEOUT_EN to also cover the forced-release budget.
`timescale 1ns/1ps
module tb_baud_sched;

  localparam int NREQ = 4;
`ifdef BAUD_SCHED_TIMEOUT_EN
  localparam int TB_MAX = 4;
`else
  localparam int TB_MAX = 4096;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [11:0] baud_code = '0;
  logic        gen_clk = 1'b0;
  logic [16:0] gen_baud;
  logic        gen_rst;
  logic [3:0]  grant;
  logic        tick;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  // reference model state (transaction level)
  int m_ptr;
  bit m_valid;
  int m_cur;

  baud_sched #(.NREQ(NREQ), .CFG_CYCLES(2), .SETTLE_CYCLES(2), .MAX_EDGES(TB_MAX)) dut (
    .clk(clk), .rst(rst), .req(req), .baud_code(baud_code), .gen_clk(gen_clk),
    .gen_baud(gen_baud), .gen_rst(gen_rst), .grant(grant), .tick(tick), .busy(busy)
  );

  always #10 clk = ~clk;

  function automatic int exp_baud(input int c);
    int tbl [8] = '{4800, 9600, 14400, 19200, 38400, 57600, 9600, 9600};
    return tbl[c & 7];
  endfunction

  // tx_clk period of the generator in clk cycles (tx_clk = 2 x baud)
  function automatic int period_of(input logic [16:0] b);
    if ($isunknown(b) || b == 0) return 2;
    return (25_000_000 + int'(b) / 2) / int'(b);
  endfunction

  // generator model: latches divider while in reset, free-runs otherwise
  int g_per = 2;
  int g_cnt = 0;
  always @(posedge clk) begin
    if (gen_rst !== 1'b0) begin
      g_cnt   <= 0;
      gen_clk <= 1'b0;
      g_per   <= period_of(gen_baud);
    end else begin
      g_cnt   <= (g_cnt >= g_per - 1) ? 0 : g_cnt + 1;
      gen_clk <= (g_cnt < g_per / 2);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    m_ptr = 0;
    m_valid = 0;
    m_cur = 1;
  endtask

  task automatic wait_grant(input int budget, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (grant == '0 && lat < budget);
  endtask

  task automatic wait_tick(input int budget, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!tick && cyc < budget);
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (grant !== 4'b0)        begin n_err++; $display("FAIL reset_grant: got %b want 0000", grant); end
    n_vec++; if (tick !== 1'b0)         begin n_err++; $display("FAIL reset_tick: got %b want 0", tick); end
    n_vec++; if (busy !== 1'b0)         begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (gen_rst !== 1'b1)      begin n_err++; $display("FAIL reset_gen_rst: got %b want 1", gen_rst); end
    n_vec++; if (gen_baud !== 17'd9600) begin n_err++; $display("FAIL reset_gen_baud: got %0d want 9600", gen_baud); end
  endtask

  task automatic test_single();
    int cyc;
    logic [3:0] eg;
    do_reset();
    baud_code = 12'h001;
    req = 4'b0001;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      eg = (c == 5) ? 4'b0001 : 4'b0000;
      n_vec++; if (grant !== eg) begin n_err++; $display("FAIL single_grant c%0d: got %b want %b", c, grant, eg); end
      n_vec++; if (gen_rst !== (c <= 2)) begin n_err++; $display("FAIL single_gen_rst c%0d: got %b want %b", c, gen_rst, (c <= 2)); end
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy c%0d: got %b want 1", c, busy); end
    end
    n_vec++; if (gen_baud !== 17'd9600) begin n_err++; $display("FAIL single_gen_baud: got %0d want 9600", gen_baud); end
    wait_tick(6000, cyc);
    wait_tick(6000, cyc);
    n_vec++; if (cyc != period_of(17'(exp_baud(1)))) begin n_err++; $display("FAIL single_tick_period: got %0d want %0d", cyc, period_of(17'(exp_baud(1)))); end
    n_vec++; if (grant !== 4'b0001) begin n_err++; $display("FAIL single_hold: got %b want 0001", grant); end
    req = '0;
    @(negedge clk);
    n_vec++; if (grant !== 4'b0) begin n_err++; $display("FAIL single_release: got %b want 0000", grant); end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int lat, cyc;
    logic [3:0] eg;
    do_reset();
    baud_code = {4{3'd5}};
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wait_grant(20, lat);
      eg = 4'b0001 << i;
      n_vec++; if (grant !== eg) begin n_err++; $display("FAIL rr_grant%0d: got %b want %b", i, grant, eg); end
      n_vec++; if (lat != ((i == 0) ? 5 : 3)) begin n_err++; $display("FAIL rr_latency%0d: got %0d want %0d", i, lat, (i == 0) ? 5 : 3); end
      for (int t = 0; t < 3; t++) wait_tick(2000, cyc);
      n_vec++; if (tick !== 1'b1 || grant !== eg) begin n_err++; $display("FAIL rr_ticks%0d: tick %b grant %b want 1 %b", i, tick, grant, eg); end
      req[i] = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    n_vec++; if (busy !== 1'b0 || grant !== 4'b0) begin n_err++; $display("FAIL rr_idle: busy %b grant %b want 0 0000", busy, grant); end
  endtask

  task automatic test_reconfig();
    int lat, cyc;
    do_reset();
    baud_code = {3'd0, 3'd0, 3'd0, 3'd5};
    req = 4'b0001;
    wait_grant(20, lat);
    n_vec++; if (grant !== 4'b0001 || gen_baud !== 17'd57600) begin n_err++; $display("FAIL recfg_first: grant %b baud %0d want 0001 57600", grant, gen_baud); end
    req = 4'b0100;
    wait_grant(20, lat);
    n_vec++; if (grant !== 4'b0100) begin n_err++; $display("FAIL recfg_grant: got %b want 0100", grant); end
    n_vec++; if (lat != 7) begin n_err++; $display("FAIL recfg_latency: got %0d want 7", lat); end
    n_vec++; if (gen_baud !== 17'd4800) begin n_err++; $display("FAIL recfg_gen_baud: got %0d want 4800", gen_baud); end
    wait_tick(12000, cyc);
    wait_tick(12000, cyc);
    n_vec++; if (cyc != period_of(17'(exp_baud(0)))) begin n_err++; $display("FAIL recfg_tick_period: got %0d want %0d", cyc, period_of(17'(exp_baud(0)))); end
    req = '0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_settle_drop();
    int lat;
    bit seen;
    do_reset();
    baud_code = 12'h001;
    req = 4'b0001;
    seen = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (grant !== 4'b0) seen = 1;
    end
    req = '0;
    @(negedge clk);
    if (grant !== 4'b0) seen = 1;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL drop_release_busy: got %b want 1", busy); end
    @(negedge clk);
    if (grant !== 4'b0) seen = 1;
    n_vec++; if (seen) begin n_err++; $display("FAIL drop_no_grant: got pulse want none"); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL drop_idle_busy: got %b want 0", busy); end
    req = 4'b0001;
    wait_grant(20, lat);
    n_vec++; if (lat != 5 || grant !== 4'b0001) begin n_err++; $display("FAIL drop_recfg: lat %0d grant %b want 5 0001", lat, grant); end
    req = '0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_active();
    int lat;
    do_reset();
    baud_code = 12'h003;
    req = 4'b0001;
    wait_grant(20, lat);
    n_vec++; if (grant !== 4'b0001 || gen_baud !== 17'd19200) begin n_err++; $display("FAIL rsta_grant: grant %b baud %0d want 0001 19200", grant, gen_baud); end
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (grant !== 4'b0)        begin n_err++; $display("FAIL rsta_grant0: got %b want 0000", grant); end
    n_vec++; if (gen_rst !== 1'b1)      begin n_err++; $display("FAIL rsta_gen_rst: got %b want 1", gen_rst); end
    n_vec++; if (gen_baud !== 17'd9600) begin n_err++; $display("FAIL rsta_gen_baud: got %0d want 9600", gen_baud); end
    n_vec++; if (busy !== 1'b0 || tick !== 1'b0) begin n_err++; $display("FAIL rsta_busy_tick: got %b %b want 0 0", busy, tick); end
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    req = 4'b0001;
    wait_grant(20, lat);
    n_vec++; if (lat != 5) begin n_err++; $display("FAIL rsta_recfg_latency: got %0d want 5", lat); end
    req = '0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_random();
    int lat, w, wcode, h;
    bit skip;
    logic [3:0] mask, eg;
    do_reset();
    baud_code = 12'($urandom);
    for (int r = 0; r < 12; r++) begin
      mask = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 1) == 1) baud_code = 12'($urandom);
      w = -1;
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && mask[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      wcode = int'(baud_code[3*w +: 3]);
      skip = m_valid && (wcode == m_cur);
      req = mask;
      wait_grant(20, lat);
      eg = 4'b0001 << w;
      n_vec++; if (grant !== eg) begin n_err++; $display("FAIL rand%0d_grant: got %b want %b", r, grant, eg); end
      n_vec++; if (lat != (skip ? 1 : 5)) begin n_err++; $display("FAIL rand%0d_latency: got %0d want %0d", r, lat, skip ? 1 : 5); end
      n_vec++; if (gen_baud !== 17'(exp_baud(wcode))) begin n_err++; $display("FAIL rand%0d_gen_baud: got %0d want %0d", r, gen_baud, exp_baud(wcode)); end
      m_ptr = (w + 1) % NREQ;
      m_valid = 1;
      m_cur = wcode;
      h = $urandom_range(0, 20);
      for (int c = 0; c < h; c++) begin
        @(negedge clk);
        if (c == h / 2) baud_code = 12'($urandom);
      end
      n_vec++; if (grant !== eg) begin n_err++; $display("FAIL rand%0d_hold: got %b want %b", r, grant, eg); end
      req = '0;
      @(negedge clk);
      n_vec++; if (grant !== 4'b0) begin n_err++; $display("FAIL rand%0d_release: got %b want 0000", r, grant); end
      @(negedge clk);
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rand%0d_idle: got %b want 0", r, busy); end
    end
  endtask

`ifdef BAUD_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int lat, nt, last_t, cyc;
    do_reset();
    baud_code = {4{3'd5}};
    req = 4'b0011;
    wait_grant(20, lat);
    n_vec++; if (grant !== 4'b0001) begin n_err++; $display("FAIL tmo_grant0: got %b want 0001", grant); end
    nt = 0;
    last_t = 0;
    cyc = 0;
    while (grant == 4'b0001 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (tick) begin nt++; last_t = cyc; end
    end
    n_vec++; if (nt != 4) begin n_err++; $display("FAIL tmo_ticks: got %0d want 4", nt); end
    n_vec++; if (cyc != last_t + 1 || grant !== 4'b0) begin n_err++; $display("FAIL tmo_release: at %0d (grant %b) want %0d (0000)", cyc, grant, last_t + 1); end
    wait_grant(20, lat);
    n_vec++; if (grant !== 4'b0010 || lat != 2) begin n_err++; $display("FAIL tmo_grant1: grant %b lat %0d want 0010 2", grant, lat); end
    req = '0;
    @(negedge clk);
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_reconfig();
    test_settle_drop();
    test_reset_active();
    test_random();
`ifdef BAUD_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
